mux_nto1_rr: RTL

Parametrised N-to-1 data multiplexer. It is the successor to the team's 2-to-1 combinational muxes (cond/if/case styles).
- Adds a registered output stage with a valid/ready handshake.
- Supports two modes: explicit select, or fair round-robin selection among requesting channels.
- Sits between multiple producer channels and a single consumer in the practice datapaths.

---
 rtl/mux_nto1_rr_pkg.sv | 12 +
 rtl/mux_nto1_rr_if.sv | 30 +++
 rtl/mux_nto1_rr_arbiter.sv | 32 +++
 rtl/mux_nto1_rr.sv | 102 ++++++++++
 4 files changed

// File: rtl/mux_nto1_rr_pkg.sv
// Shared mode encodings and sizing helper for the N-to-1 round-robin mux.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Index width that stays at least one bit, so N=2 still yields a usable select.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_rr_if.sv
// Producer-side and consumer-side handshake bundle for mux_nto1_rr.
interface mux_nto1_rr_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = clog2_min1(N);

    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [N*WIDTH-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/mux_nto1_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
// Zero latency; no state, the caller owns the pointer.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            gnt_valid_o,
    output logic [SELW-1:0] gnt_idx_o
);

    int unsigned j;

    // Scan offsets from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        j           = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[j]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = SELW'(j);
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 mux with explicit-select or round-robin grant and a registered output stage.
// One cycle input-to-output latency; in_ready drops for all channels while output is held.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic clk,
    input  logic rst,
    mux_nto1_rr_if.slave bus
);
    localparam int SELW = clog2_min1(N);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;

    logic             rr_vld;
    logic [SELW-1:0]  rr_idx;
    logic             sel_vld;
    logic [SELW-1:0]  sel_idx;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load;
    logic             xfer;
    logic [N-1:0]     in_ready;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req_i       (bus.in_valid),
        .ptr_i       (ptr_q),
        .gnt_valid_o (rr_vld),
        .gnt_idx_o   (rr_idx)
    );

    // Explicit select matches against real channel indices only, so sel >= N grants nothing.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                sel_vld = 1'b1;
                sel_idx = SELW'(i);
            end
        end
    end

    assign gnt_vld = (bus.mode == MODE_RR) ? rr_vld : sel_vld;
    assign gnt_idx = (bus.mode == MODE_RR) ? rr_idx : sel_idx;
    assign load    = ~out_valid_q | bus.out_ready;
    assign xfer    = load & gnt_vld & ~rst;

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                in_ready[i] = xfer;
                gnt_data    = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = gnt_vld;
        end
        if (xfer) begin
            out_data_d = gnt_data;
            out_chan_d = gnt_idx;
            if (bus.mode == MODE_RR) begin
                ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule
